// File: rtl/axi_lite_mem_if.sv
// AXI4-Lite bus bundle between a master and the axi_lite_mem responder.
interface axi_lite_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddress;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddress;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport slave (
        input  awvalid, awaddress, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddress, arprot,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddress, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddress, arprot,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_mem.sv
// AXI4-Lite slave memory: configurable depth, base address, per-channel
// latency, a read-only low region and decode errors outside the window.
// Read and write channels are independent, one outstanding transaction each.
module axi_lite_mem #(
    parameter int unsigned            ADDR_WIDTH    = 32,
    parameter int unsigned            DEPTH_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR     = '0,
    parameter int unsigned            READ_LATENCY  = 1,
    parameter int unsigned            WRITE_LATENCY = 1,
    parameter int unsigned            PROTECT_WORDS = 0
) (
    input logic           clk,
    input logic           reset,
    axi_lite_mem_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WCW   = $clog2(WRITE_LATENCY + 1);
    localparam int unsigned RCW   = $clog2(READ_LATENCY + 1);

    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_WORDS);
    localparam logic [WCW-1:0]      W_CNT_INIT = WCW'(WRITE_LATENCY - 1);
    localparam logic [RCW-1:0]      R_CNT_INIT = RCW'(READ_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    logic [31:0] mem [DEPTH_WORDS];

    // Write channel state
    logic [1:0]            w_state;
    logic                  aw_held;
    logic                  wd_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic [WCW-1:0]        w_cnt;

    // Read channel state
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [RCW-1:0]        r_cnt;

    // Decode is done one bit wider so an address below BASE_ADDR shows up as a borrow
    logic [ADDR_WIDTH:0] w_diff;
    logic [ADDR_WIDTH:0] w_idx;
    logic                w_in_range;
    logic                w_prot;
    logic [ADDR_WIDTH:0] r_diff;
    logic [ADDR_WIDTH:0] r_idx;
    logic                r_in_range;

    assign w_diff     = {1'b0, aw_addr} - BASE_EXT;
    assign w_idx      = {2'b00, w_diff[ADDR_WIDTH:2]};
    assign w_in_range = !w_diff[ADDR_WIDTH] && (w_idx < DEPTH_EXT);

    assign r_diff     = {1'b0, ar_addr} - BASE_EXT;
    assign r_idx      = {2'b00, r_diff[ADDR_WIDTH:2]};
    assign r_in_range = !r_diff[ADDR_WIDTH] && (r_idx < DEPTH_EXT);

    generate
        if (PROTECT_WORDS == 0) begin : g_no_protect
            assign w_prot = 1'b0;
        end else begin : g_protect
            assign w_prot = w_idx < (ADDR_WIDTH + 1)'(PROTECT_WORDS);
        end
    endgenerate

    // Byte-offset bits and protection attributes carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{bus.awprot, bus.arprot, w_diff[1:0], r_diff[1:0]};

    logic aw_hs;
    logic w_hs;
    logic aw_have;
    logic wd_have;
    logic commit;
    logic commit_ok;
    logic ar_hs;

    assign aw_hs     = bus.awvalid && bus.awready;
    assign w_hs      = bus.wvalid && bus.wready;
    assign aw_have   = aw_held || aw_hs;
    assign wd_have   = wd_held || w_hs;
    assign commit    = (w_state == W_WAIT) && (w_cnt == '0);
    assign commit_ok = commit && w_in_range && !w_prot;
    assign ar_hs     = bus.arvalid && bus.arready;

    // Write FSM: collect AW and W in any order, wait out the latency, then respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state     <= W_IDLE;
            aw_held     <= 1'b0;
            wd_held     <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            w_cnt       <= '0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr <= bus.awaddress;
                    end
                    if (w_hs) begin
                        w_data <= bus.wdata;
                        w_strb <= bus.wstrb;
                    end
                    if (aw_have && wd_have) begin
                        aw_held     <= 1'b0;
                        wd_held     <= 1'b0;
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b0;
                        w_cnt       <= W_CNT_INIT;
                        w_state     <= W_WAIT;
                    end else begin
                        aw_held     <= aw_have;
                        wd_held     <= wd_have;
                        bus.awready <= !aw_have;
                        bus.wready  <= !wd_have;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == '0) begin
                        bus.bvalid <= 1'b1;
                        bus.bresp  <= !w_in_range ? RESP_DECERR :
                                      w_prot      ? RESP_SLVERR : RESP_OKAY;
                        w_state    <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 1'b1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory array is never reset; commit is gated by the reset-cleared write FSM
    always_ff @(posedge clk) begin
        if (commit_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    mem[w_idx[IDX_W-1:0]][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Read FSM: latch AR, wait out the latency, sample memory (pre-write value on collision)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= R_IDLE;
            ar_addr     <= '0;
            r_cnt       <= '0;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr     <= bus.araddress;
                        r_cnt       <= R_CNT_INIT;
                        bus.arready <= 1'b0;
                        r_state     <= R_WAIT;
                    end else begin
                        bus.arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        bus.rvalid <= 1'b1;
                        bus.rdata  <= r_in_range ? mem[r_idx[IDX_W-1:0]] : '0;
                        bus.rresp  <= r_in_range ? RESP_OKAY : RESP_DECERR;
                        r_state    <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        bus.rvalid  <= 1'b0;
                        bus.arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_mem.sv
// Scoreboard bench for axi_lite_mem: two instances with different
// parameter sets share one driver through a select mux.
module tb_axi_lite_mem;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] awaddress = '0, araddress = '0, wdata = '0;
    logic [3:0]  wstrb = '0;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    axi_lite_mem_if #(.ADDR_WIDTH(32)) bus0 ();
    axi_lite_mem_if #(.ADDR_WIDTH(32)) bus1 ();

    assign bus0.awvalid = awvalid && !sel;   assign bus1.awvalid = awvalid && sel;
    assign bus0.wvalid  = wvalid && !sel;    assign bus1.wvalid  = wvalid && sel;
    assign bus0.arvalid = arvalid && !sel;   assign bus1.arvalid = arvalid && sel;
    assign bus0.bready  = bready && !sel;    assign bus1.bready  = bready && sel;
    assign bus0.rready  = rready && !sel;    assign bus1.rready  = rready && sel;
    assign bus0.awaddress = awaddress;       assign bus1.awaddress = awaddress;
    assign bus0.araddress = araddress;       assign bus1.araddress = araddress;
    assign bus0.wdata = wdata;               assign bus1.wdata = wdata;
    assign bus0.wstrb = wstrb;               assign bus1.wstrb = wstrb;
    assign bus0.awprot = 3'b010;             assign bus1.awprot = 3'b001;
    assign bus0.arprot = 3'b100;             assign bus1.arprot = 3'b000;

    assign awready = sel ? bus1.awready : bus0.awready;
    assign wready  = sel ? bus1.wready  : bus0.wready;
    assign bvalid  = sel ? bus1.bvalid  : bus0.bvalid;
    assign bresp   = sel ? bus1.bresp   : bus0.bresp;
    assign arready = sel ? bus1.arready : bus0.arready;
    assign rvalid  = sel ? bus1.rvalid  : bus0.rvalid;
    assign rdata   = sel ? bus1.rdata   : bus0.rdata;
    assign rresp   = sel ? bus1.rresp   : bus0.rresp;

    axi_lite_mem #(
        .ADDR_WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000),
        .READ_LATENCY(1), .WRITE_LATENCY(1), .PROTECT_WORDS(2)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    axi_lite_mem #(
        .ADDR_WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000),
        .READ_LATENCY(4), .WRITE_LATENCY(3), .PROTECT_WORDS(0)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    int compared = 0;
    int mismatched = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got no handshake within the cycle budget, required one", name);
    endtask

    // Monitor: pop the expected response whenever a B or R handshake is about to happen
    initial begin : monitor
        logic [1:0]  eb;
        logic [33:0] er;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_b: got bresp %b, required no response", bresp);
                    end else begin
                        eb = bq.pop_front();
                        chk("bresp", 32'(bresp), 32'(eb));
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_r: got rdata 0x%08h, required no response", rdata);
                    end else begin
                        er = rq.pop_front();
                        chk("rresp", 32'(rresp), 32'(er[33:32]));
                        chk("rdata", rdata, er[31:0]);
                    end
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        logic hs;
        awaddress = a; awvalid = 1'b1;
        do begin @(negedge clk); hs = awready; @(posedge clk); #1; n++; end while (!hs && n < 20);
        awvalid = 1'b0;
        if (!hs) timed_out("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic hs;
        wdata = d; wstrb = s; wvalid = 1'b1;
        do begin @(negedge clk); hs = wready; @(posedge clk); #1; n++; end while (!hs && n < 20);
        wvalid = 1'b0;
        if (!hs) timed_out("w_handshake");
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        logic hs;
        araddress = a; arvalid = 1'b1;
        do begin @(negedge clk); hs = arready; @(posedge clk); #1; n++; end while (!hs && n < 20);
        arvalid = 1'b0;
        if (!hs) timed_out("ar_handshake");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input logic [1:0] exp_resp, input int exp_lat,
                            input logic hold_b);
        int lat = 0;
        int n = 0;
        bq.push_back(exp_resp);
        if (hold_b) bready = 1'b0;
        if (w_lead == 0) begin
            fork
                send_aw(a);
                send_w(d, s);
            join
        end else begin
            send_w(d, s);
            repeat (w_lead - 1) @(posedge clk);
            #1;
            send_aw(a);
        end
        do begin @(posedge clk); #1; lat++; end while (!bvalid && lat < 40);
        chk("b_latency", 32'(lat), 32'(exp_lat));
        if (hold_b) begin
            for (int i = 0; i < 5; i++) begin
                chk("b_hold_bvalid", 32'(bvalid), 32'd1);
                chk("b_hold_bresp", 32'(bresp), 32'(exp_resp));
                chk("b_hold_awready", 32'(awready), 32'd0);
                @(posedge clk); #1;
            end
            bready = 1'b1;
        end
        while (bvalid && n < 10) begin @(posedge clk); #1; n++; end
        if (bvalid) timed_out("b_handshake");
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int exp_lat);
        int lat = 0;
        int n = 0;
        rq.push_back({exp_resp, exp_data});
        send_ar(a);
        do begin @(posedge clk); #1; lat++; end while (!rvalid && lat < 40);
        chk("r_latency", 32'(lat), 32'(exp_lat));
        while (rvalid && n < 10) begin @(posedge clk); #1; n++; end
        if (rvalid) timed_out("r_handshake");
    endtask

    task automatic chk_zero_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0.1;
            chk({tag, "_awready"}, 32'(awready), 32'd0);
            chk({tag, "_wready"},  32'(wready),  32'd0);
            chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
            chk({tag, "_bresp"},   32'(bresp),   32'd0);
            chk({tag, "_arready"}, 32'(arready), 32'd0);
            chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
            chk({tag, "_rdata"},   rdata,        32'd0);
            chk({tag, "_rresp"},   32'(rresp),   32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values and first ready rise
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        sel = 1'b0;
        reset = 1'b0;
        #1;
        chk("awready_before_edge", 32'(awready), 32'd0);
        @(posedge clk); #1;
        chk("awready_first", 32'(awready), 32'd1);
        chk("wready_first",  32'(wready),  32'd1);
        chk("arready_first", 32'(arready), 32'd1);

        // Long-latency instance: write then read back
        sel = 1'b1; #1;
        do_write(32'h1004, 32'hDEADBEEF, 4'hF, 0, OKAY, 3, 1'b0);
        do_read(32'h1004, 32'hDEADBEEF, OKAY, 4);

        // Minimum-latency instance
        sel = 1'b0; #1;
        dut0.mem[5] = 32'h11223344;
        do_write(32'h1014, 32'hAABBCCDD, 4'b0101, 0, OKAY, 1, 1'b0);
        do_read(32'h1014, 32'h11BB33DD, OKAY, 1);

        // Decode errors above and below the window
        do_read(32'h1040, 32'h0, DECERR, 1);
        do_read(32'h0FFC, 32'h0, DECERR, 1);
        do_write(32'h1040, 32'h01010101, 4'hF, 0, DECERR, 1, 1'b0);

        // Protected word: write refused, read still allowed, low address bits ignored
        dut0.mem[1] = 32'hCAFEF00D;
        do_write(32'h1004, 32'h12345678, 4'hF, 0, SLVERR, 1, 1'b0);
        chk("protected_word", dut0.mem[1], 32'hCAFEF00D);
        do_read(32'h1006, 32'hCAFEF00D, OKAY, 1);

        // Last word in range
        dut0.mem[15] = 32'h0F0F0F0F;
        do_read(32'h103C, 32'h0F0F0F0F, OKAY, 1);

        // W beat three cycles ahead of AW gives a single commit
        do_write(32'h1018, 32'h55AA55AA, 4'hF, 3, OKAY, 1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_second_b", 32'(bvalid), 32'd0);
        end
        do_read(32'h1018, 32'h55AA55AA, OKAY, 1);

        // Zero strobes: OKAY with no byte changed
        dut0.mem[7] = 32'h01020304;
        do_write(32'h101C, 32'hFFFFFFFF, 4'h0, 0, OKAY, 1, 1'b0);
        do_read(32'h101C, 32'h01020304, OKAY, 1);

        // B backpressure
        do_write(32'h1020, 32'h87654321, 4'hF, 0, OKAY, 1, 1'b1);
        do_read(32'h1020, 32'h87654321, OKAY, 1);

        // Reset during the write wait: no commit, outputs cleared
        sel = 1'b1; #1;
        dut1.mem[3] = 32'h5A5A5A5A;
        fork
            send_aw(32'h100C);
            send_w(32'h00000000, 4'hF);
        join
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("mid_reset");
        sel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_reset_bvalid", 32'(bvalid), 32'd0);
        end
        chk("aborted_write_word", dut1.mem[3], 32'h5A5A5A5A);
        do_read(32'h100C, 32'h5A5A5A5A, OKAY, 4);

        repeat (2) @(posedge clk);
        chk("b_queue_drained", 32'(bq.size()), 32'd0);
        chk("r_queue_drained", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
